xif_copro_result_tx: RTL and testbench

Result-side transmitter of the XIF coprocessor. It buffers results from the coprocessor execution units in program order and returns them to the core over the XIF result interface (valid/ready). Each result is gated by the core's commit decision, so only committed instructions are ever reported. The block is the return path for instructions accepted by the issue-side predecoder.

---
 rtl/xif_copro_result_tx.sv | 95 +++++++++
 tb/tb_xif_copro_result_tx.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xif_copro_result_tx.sv
// xif_copro_result_tx: in-order result FIFO gated by a per-id commit/kill table
module xif_copro_result_tx #(
    parameter int X_ID_WIDTH = 4,
    parameter int XLEN       = 32,
    parameter int DEPTH      = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     exec_valid_i,
    output logic                     exec_ready_o,
    input  logic [X_ID_WIDTH-1:0]    exec_id_i,
    input  logic [4:0]               exec_rd_i,
    input  logic [XLEN-1:0]          exec_data_i,
    input  logic                     exec_we_i,
    input  logic                     commit_valid_i,
    input  logic [X_ID_WIDTH-1:0]    commit_id_i,
    input  logic                     commit_kill_i,
    output logic                     result_valid_o,
    input  logic                     result_ready_i,
    output logic [X_ID_WIDTH-1:0]    result_id_o,
    output logic [4:0]               result_rd_o,
    output logic [XLEN-1:0]          result_data_o,
    output logic                     result_we_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     busy_o
);
    localparam int AW  = $clog2(DEPTH);
    localparam int NID = 1 << X_ID_WIDTH;

    logic [X_ID_WIDTH-1:0] id_q   [DEPTH];
    logic [4:0]            rd_q   [DEPTH];
    logic [XLEN-1:0]       data_q [DEPTH];
    logic [DEPTH-1:0]      we_q;
    logic [AW:0]           wptr, rptr;
    logic [NID-1:0]        committed, killed;
    logic                  empty, full, push, pop, head_killed;
    logic [AW-1:0]         widx, ridx;

    assign widx           = wptr[AW-1:0];
    assign ridx           = rptr[AW-1:0];
    assign empty          = wptr == rptr;
    assign full           = (wptr[AW] != rptr[AW]) && (widx == ridx);
    assign exec_ready_o   = !full;
    assign push           = exec_valid_i && !full;
    assign result_id_o    = id_q[ridx];
    assign result_rd_o    = rd_q[ridx];
    assign result_data_o  = data_q[ridx];
    assign result_we_o    = we_q[ridx];
    // A killed head is dropped silently; a committed one is offered to the core.
    assign head_killed    = !empty && killed[result_id_o];
    assign result_valid_o = !empty && committed[result_id_o] && !killed[result_id_o];
    assign pop            = head_killed || (result_valid_o && result_ready_i);
    assign count_o        = wptr - rptr;
    assign busy_o         = !empty || (|committed) || (|killed);

    // Result storage and pointers; storage is reset so empty-FIFO outputs are never X.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr <= '0;
            rptr <= '0;
            we_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                id_q[i]   <= '0;
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (push) begin
                id_q[widx]   <= exec_id_i;
                rd_q[widx]   <= exec_rd_i;
                data_q[widx] <= exec_data_i;
                we_q[widx]   <= exec_we_i;
                wptr         <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
        end
    end

    // Commit table: popping clears the head id, a same-cycle commit/kill of that id wins.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            committed <= '0;
            killed    <= '0;
        end else begin
            if (pop) begin
                committed[result_id_o] <= 1'b0;
                killed[result_id_o]    <= 1'b0;
            end
            if (commit_valid_i) begin
                if (commit_kill_i) killed[commit_id_i] <= 1'b1;
                else committed[commit_id_i] <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_xif_copro_result_tx.sv
// tb_xif_copro_result_tx: scoreboard bench with directed scenarios and randomized rounds
module tb_xif_copro_result_tx;
    typedef struct packed {
        logic [3:0]  id;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        we;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        exec_valid = 1'b0, exec_ready, exec_we = 1'b0;
    logic [3:0]  exec_id = '0;
    logic [4:0]  exec_rd = '0;
    logic [31:0] exec_data = '0;
    logic        commit_valid = 1'b0, commit_kill = 1'b0;
    logic [3:0]  commit_id = '0;
    logic        result_valid, result_ready = 1'b0, result_we;
    logic [3:0]  result_id;
    logic [4:0]  result_rd;
    logic [31:0] result_data;
    logic [2:0]  count;
    logic        busy;

    res_t sb[$];
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    xif_copro_result_tx #(.X_ID_WIDTH(4), .XLEN(32), .DEPTH(4)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .exec_valid_i(exec_valid), .exec_ready_o(exec_ready), .exec_id_i(exec_id),
        .exec_rd_i(exec_rd), .exec_data_i(exec_data), .exec_we_i(exec_we),
        .commit_valid_i(commit_valid), .commit_id_i(commit_id), .commit_kill_i(commit_kill),
        .result_valid_o(result_valid), .result_ready_i(result_ready), .result_id_o(result_id),
        .result_rd_o(result_rd), .result_data_o(result_data), .result_we_o(result_we),
        .count_o(count), .busy_o(busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        exec_valid   = 1'b0;
        commit_valid = 1'b0;
    endtask

    task automatic drive_push(input res_t r, input bit also_commit, input bit expect_out);
        exec_valid = 1'b1;
        exec_id    = r.id;
        exec_rd    = r.rd;
        exec_data  = r.data;
        exec_we    = r.we;
        commit_valid = also_commit;
        commit_id    = r.id;
        commit_kill  = 1'b0;
        if (expect_out) sb.push_back(r);
    endtask

    task automatic decide(input logic [3:0] id, input bit kill);
        commit_valid = 1'b1;
        commit_id    = id;
        commit_kill  = kill;
    endtask

    function automatic res_t mk(input logic [3:0] id, input logic [4:0] rd, input logic [31:0] d, input logic we);
        res_t r;
        r.id = id; r.rd = rd; r.data = d; r.we = we;
        return r;
    endfunction

    // Monitor: every handshake must match the oldest committed entry; held results must stay stable
    initial begin : monitor
        res_t cur, prev;
        logic prev_hold;
        prev_hold = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = {result_id, result_rd, result_data, result_we};
            if (rst_n) begin
                if (prev_hold) check("hold", {1'b1, cur}, {1'b1 & result_valid, prev});
                if (result_valid && result_ready) begin
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_result: got id %0h with no result expected", result_id);
                    end else check("result", cur, sb.pop_front());
                end
                prev_hold = result_valid && !result_ready;
                prev = cur;
            end else prev_hold = 1'b0;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : main
        res_t tx[4];
        bit   kl[4];
        int   ord[4];
        int   k, g, j, t;
        logic [3:0] next_id;
        res_t held;

        step;
        check("rst_ready", exec_ready, 1);
        check("rst_valid", result_valid, 0);
        check("rst_count", count, 0);
        check("rst_busy", busy, 0);
        check("rst_fields", {result_id, result_rd, result_data, result_we}, 0);
        rst_n = 1'b1;
        step;

        // Basic commit-first
        result_ready = 1'b1;
        decide(4'd3, 1'b0);
        step;
        drive_push(mk(4'd3, 5'd5, 32'hDEADBEEF, 1'b1), 1'b0, 1'b1);
        step;
        idle;
        check("basic_valid", result_valid, 1);
        check("basic_fields", {result_id, result_rd, result_data, result_we}, {4'd3, 5'd5, 32'hDEADBEEF, 1'b1});
        step;
        check("basic_count", count, 0);
        check("basic_busy", busy, 0);

        // Late commit with stall
        drive_push(mk(4'd1, 5'd11, 32'h1111_0001, 1'b0), 1'b0, 1'b1);
        decide(4'd2, 1'b0);
        step;
        drive_push(mk(4'd2, 5'd12, 32'h2222_0002, 1'b1), 1'b0, 1'b1);
        commit_valid = 1'b0;
        step;
        idle;
        check("stall_0", result_valid, 0);
        step;
        check("stall_1", result_valid, 0);
        decide(4'd1, 1'b0);
        step;
        idle;
        check("late_id1", {result_valid, result_id}, {1'b1, 4'd1});
        step;
        check("late_id2", {result_valid, result_id}, {1'b1, 4'd2});
        step;
        check("late_busy", busy, 0);

        // Kill drop
        drive_push(mk(4'd0, 5'd1, 32'hA0, 1'b1), 1'b0, 1'b1);
        step;
        drive_push(mk(4'd1, 5'd2, 32'hA1, 1'b1), 1'b0, 1'b0);
        step;
        drive_push(mk(4'd2, 5'd3, 32'hA2, 1'b0), 1'b0, 1'b1);
        step;
        exec_valid = 1'b0;
        decide(4'd0, 1'b0);
        step;
        decide(4'd1, 1'b1);
        step;
        decide(4'd2, 1'b0);
        step;
        idle;
        repeat (4) step;
        check("kill_count", count, 0);
        check("kill_busy", busy, 0);

        // Backpressure, full, stability, back-to-back drain, wrap
        result_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tx[i] = mk(4'(8 + i), 5'(20 + i), $urandom, 1'(i));
            drive_push(tx[i], 1'b1, 1'b1);
            step;
        end
        idle;
        check("bp_ready", exec_ready, 0);
        check("bp_count", count, 4);
        check("bp_valid", result_valid, 1);
        held = {result_id, result_rd, result_data, result_we};
        check("bp_head", held, tx[0]);
        for (int i = 0; i < 10; i++) begin
            step;
            check("bp_stable", {result_valid, result_id, result_rd, result_data, result_we}, {1'b1, held});
        end
        result_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("b2b", {result_valid, result_id}, {1'b1, 4'(8 + i)});
            step;
        end
        check("b2b_count", count, 0);
        for (int i = 0; i < 4; i++) begin
            drive_push(mk(4'(12 + i), 5'(i), $urandom, 1'b1), 1'b1, 1'b1);
            step;
        end
        idle;
        repeat (3) step;
        check("wrap_count", count, 0);
        check("wrap_busy", busy, 0);

        // Id reuse: new commit of id 7 lands in the handshake cycle of the old id 7
        result_ready = 1'b0;
        drive_push(mk(4'd7, 5'd1, 32'h7000_0001, 1'b1), 1'b1, 1'b1);
        step;
        idle;
        check("reuse_first", {result_valid, result_id}, {1'b1, 4'd7});
        result_ready = 1'b1;
        decide(4'd7, 1'b0);
        step;
        commit_valid = 1'b0;
        check("reuse_busy", {result_valid, busy}, {1'b0, 1'b1});
        drive_push(mk(4'd7, 5'd2, 32'h7000_0002, 1'b0), 1'b0, 1'b1);
        step;
        idle;
        check("reuse_second", {result_valid, result_id, result_rd}, {1'b1, 4'd7, 5'd2});
        step;
        check("reuse_busy_end", busy, 0);

        // Mid-stream reset
        result_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_push(mk(4'(4 + i), 5'(i), $urandom, 1'b1), 1'b1, 1'b1);
            step;
        end
        idle;
        check("mr_pre", {result_valid, count}, {1'b1, 3'd3});
        #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("mr_valid", result_valid, 0);
        check("mr_count", count, 0);
        check("mr_busy", busy, 0);
        check("mr_ready", exec_ready, 1);
        check("mr_fields", {result_id, result_rd, result_data, result_we}, 0);
        step;
        step;
        rst_n = 1'b1;
        result_ready = 1'b1;
        repeat (5) step;
        check("mr_after", {result_valid, count, busy}, 0);

        // Randomized rounds against a queue model: in-order, committed-only delivery
        next_id = '0;
        for (int r = 0; r < 150; r++) begin
            k = $urandom_range(1, 4);
            for (int i = 0; i < k; i++) begin
                tx[i] = mk(next_id, 5'($urandom), $urandom, 1'($urandom));
                next_id = next_id + 1'b1;
                kl[i] = ($urandom_range(0, 3) == 0);
                if (!kl[i]) sb.push_back(tx[i]);
                ord[i] = i;
            end
            for (int i = k - 1; i > 0; i--) begin
                j = $urandom_range(0, i);
                t = ord[i]; ord[i] = ord[j]; ord[j] = t;
            end
            fork
                begin
                    for (int i = 0; i < k; i++) begin
                        repeat ($urandom_range(0, 2)) begin
                            result_ready = 1'($urandom);
                            step;
                        end
                        exec_valid = 1'b1;
                        exec_id = tx[i].id; exec_rd = tx[i].rd;
                        exec_data = tx[i].data; exec_we = tx[i].we;
                        for (int w = 0; w < 50 && !exec_ready; w++) begin
                            result_ready = 1'($urandom);
                            step;
                        end
                        result_ready = 1'($urandom);
                        step;
                        exec_valid = 1'b0;
                    end
                end
                begin
                    for (int i = 0; i < k; i++) begin
                        repeat ($urandom_range(0, 3)) step;
                        decide(tx[ord[i]].id, kl[ord[i]]);
                        step;
                        commit_valid = 1'b0;
                    end
                end
            join
            g = 0;
            while (busy && g < 100) begin
                result_ready = 1'($urandom);
                step;
                g++;
            end
            check("rand_drain", busy, 0);
        end

        idle;
        repeat (3) step;
        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
